// File: rtl/usb_pkt_rx.sv
// rtl/usb_pkt_rx.sv - UTMI receive packet decoder: PID check, token decode, CRC5/CRC16 check, CRC strip
// Reports one pkt_done per packet with pass/fail status and error code.
module usb_pkt_rx #(
    parameter int MAX_DATA_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic [7:0]  rx_data,
    output logic [3:0]  pid,
    output logic        pid_valid,
    output logic        tok_valid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] frame_num,
    output logic        data_valid,
    output logic [7:0]  data,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [2:0]  err_code
);
    localparam int CW = $clog2(MAX_DATA_LEN + 4);
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_DATA_LEN + 2);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSHK, S_DRAIN} state_t;
    state_t state, state_nx;

    logic          act_q;
    logic [CW-1:0] cnt;
    logic [4:0]    crc5;
    logic [15:0]   crc16;
    logic [7:0]    b1;
    logic [2:0]    b2;
    logic [7:0]    h0, h1;
    logic          e_rx, e_pid, e_ovf, e_len;
    logic          set_rx, set_pid, set_ovf, set_len;
    logic          byte_ok, pid_good, eop, end_ok;
    logic [2:0]    end_code;

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[4] ^ d[i]) ? ({r[3:0], 1'b0} ^ 5'h05) : {r[3:0], 1'b0};
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
        return r;
    endfunction

    assign byte_ok  = rx_active & rx_valid & ~rx_error;
    assign pid_good = (rx_data[7:4] == ~rx_data[3:0]);
    assign eop      = (state != S_IDLE) & ~rx_active;

    always_comb begin
        state_nx = state;
        set_rx   = 1'b0;
        set_pid  = 1'b0;
        set_ovf  = 1'b0;
        set_len  = 1'b0;
        if (state == S_IDLE) begin
            if (rx_active && !act_q) state_nx = S_PID;
        end else if (!rx_active) begin
            state_nx = S_IDLE;
        end else if (rx_error) begin
            set_rx   = 1'b1;
            state_nx = S_DRAIN;
        end else if (rx_valid) begin
            case (state)
                S_PID: begin
                    if (!pid_good) begin
                        set_pid  = 1'b1;
                        state_nx = S_DRAIN;
                    end else begin
                        case (rx_data[3:0])
                            4'h1, 4'h9, 4'hD, 4'h5: state_nx = S_TOKEN;
                            4'h3, 4'hB:             state_nx = S_DATA;
                            4'h2, 4'hA, 4'hE:       state_nx = S_HSHK;
                            default: begin
                                set_len  = 1'b1;
                                state_nx = S_DRAIN;
                            end
                        endcase
                    end
                end
                S_TOKEN: if (cnt == CNT_TWO) begin
                    set_len  = 1'b1;
                    state_nx = S_DRAIN;
                end
                S_DATA: if (cnt == CNT_FULL) begin
                    set_ovf  = 1'b1;
                    state_nx = S_DRAIN;
                end
                S_HSHK: begin
                    set_len  = 1'b1;
                    state_nx = S_DRAIN;
                end
                default: ;
            endcase
        end
    end

    // Latched errors outrank anything judged at end of packet.
    always_comb begin
        end_code = 3'd0;
        if (e_rx)       end_code = 3'd5;
        else if (e_pid) end_code = 3'd1;
        else if (e_ovf) end_code = 3'd6;
        else if (e_len) end_code = 3'd4;
        else begin
            case (state)
                S_PID:   end_code = 3'd4;
                S_TOKEN: if (cnt != CNT_TWO) end_code = 3'd4;
                         else if (crc5 != 5'b01100) end_code = 3'd2;
                S_DATA:  if (cnt < CNT_TWO) end_code = 3'd4;
                         else if (crc16 != 16'h800D) end_code = 3'd3;
                default: ;
            endcase
        end
        end_ok = (end_code == 3'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            act_q <= 1'b0;
        end else begin
            state <= state_nx;
            act_q <= rx_active;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; crc5 <= 5'h1F; crc16 <= 16'hFFFF;
            b1 <= '0; b2 <= '0; h0 <= '0; h1 <= '0;
            e_rx <= 1'b0; e_pid <= 1'b0; e_ovf <= 1'b0; e_len <= 1'b0;
            pid <= '0; pid_valid <= 1'b0; tok_valid <= 1'b0;
            tok_addr <= '0; tok_endp <= '0; frame_num <= '0;
            data_valid <= 1'b0; data <= '0;
            pkt_done <= 1'b0; pkt_ok <= 1'b0; pkt_err <= 1'b0; err_code <= '0;
        end else begin
            pid_valid  <= 1'b0;
            tok_valid  <= 1'b0;
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            pkt_err    <= 1'b0;
            err_code   <= 3'd0;
            if (state == S_IDLE) begin
                cnt <= '0; crc5 <= 5'h1F; crc16 <= 16'hFFFF;
                e_rx <= 1'b0; e_pid <= 1'b0; e_ovf <= 1'b0; e_len <= 1'b0;
            end else begin
                e_rx  <= e_rx  | set_rx;
                e_pid <= e_pid | set_pid;
                e_ovf <= e_ovf | set_ovf;
                e_len <= e_len | set_len;
            end
            if (byte_ok && state == S_PID && pid_good) begin
                pid       <= rx_data[3:0];
                pid_valid <= 1'b1;
            end
            if (byte_ok && state == S_TOKEN && cnt != CNT_TWO) begin
                crc5 <= crc5_byte(crc5, rx_data);
                cnt  <= cnt + 1'b1;
                if (cnt == '0) b1 <= rx_data;
                else           b2 <= rx_data[2:0];
            end
            // Two-byte holding pipe keeps the trailing CRC16 off the data output.
            if (byte_ok && state == S_DATA && cnt != CNT_FULL) begin
                crc16 <= crc16_byte(crc16, rx_data);
                cnt   <= cnt + 1'b1;
                h0    <= rx_data;
                h1    <= h0;
                if (cnt >= CNT_TWO) begin
                    data       <= h1;
                    data_valid <= 1'b1;
                end
            end
            if (eop) begin
                pkt_done <= 1'b1;
                pkt_ok   <= end_ok;
                pkt_err  <= ~end_ok;
                err_code <= end_code;
                if (state == S_TOKEN && end_ok) begin
                    tok_valid <= 1'b1;
                    tok_addr  <= b1[6:0];
                    tok_endp  <= {b2, b1[7]};
                    frame_num <= {b2, b1};
                end
            end
        end
    end
endmodule

// File: doc/usb_pkt_rx.md
Name: usb_pkt_rx

Overview:
- UTMI receive-side packet decoder. It sits directly downstream of the FS UTM on the UTMI RX path and feeds the device protocol engine.
- Consumes the UTM's 8-bit RX byte stream framed by RxActive. Validates the PID, decodes token fields, checks CRC5 and CRC16, and strips CRC bytes from data payloads.
- Reports one completion event per packet, carrying pass/fail status and an error code.

Parameters:
- MAX_DATA_LEN, 64, maximum payload bytes (excluding PID and CRC16); longer packets are reported as errors. The length counter is $clog2(MAX_DATA_LEN+4) bits wide.

Ports:
- clk  in  1  clock, same as UTM
- rst  in  1  asynchronous, active-high reset
- rx_active  in  1  UTMI RxActive
- rx_valid  in  1  UTMI RxValid; a byte is accepted on a cycle with rx_active & rx_valid
- rx_error  in  1  UTMI RxError
- rx_data  in  8  UTMI DataOut
- pid  out  4  PID of current/last packet, held until the next PID
- pid_valid  out  1  one-cycle pulse, the cycle after the PID byte is accepted and passes its check
- tok_valid  out  1  one-cycle pulse for a good token (OUT/IN/SETUP/SOF)
- tok_addr  out  7  token address
- tok_endp  out  4  token endpoint
- frame_num  out  11  SOF frame number, {byte2[2:0], byte1}
- data_valid  out  1  payload byte strobe
- data  out  8  payload byte
- pkt_done  out  1  one-cycle end-of-packet pulse
- pkt_ok  out  1  with pkt_done: packet good
- pkt_err  out  1  with pkt_done: packet bad; pkt_ok and pkt_err are mutually exclusive
- err_code  out  3  valid with pkt_err: 1 PID check, 2 CRC5, 3 CRC16, 4 length, 5 rx_error, 6 payload overflow

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRCs and counters cleared. Asserting rst mid-packet aborts silently, with no pkt_done.
- Bytes arrive LSB-first on the wire.
- CRC5: polynomial x^5+x^2+1, init 5'h1F. Computed over token bytes 1–2 including the CRC field. Good residual is 5'b01100.
- CRC16: polynomial x^16+x^15+x^2+1, init 16'hFFFF. Computed over all payload and CRC bytes. Good residual is 16'h800D.
- CRC register convention: serial input in bit order, feedback = crc[MSB] ^ bit. Both CRCs are evaluated bytewise in one cycle.
- FSM states: IDLE, PID, TOKEN, DATA, HSHK, DRAIN.
- IDLE: on rx_active rise, go to PID.
- PID: the first byte is checked for rx_data[7:4] == ~rx_data[3:0].
  - On failure, latch err=1 and go to DRAIN.
  - On success, register pid and pulse pid_valid.
  - Token PIDs (1,9,D,5) go to TOKEN; DATA0/1 (3,B) go to DATA; handshakes ACK/NAK/STALL (2,A,E) go to HSHK.
  - Any other valid PID is treated as a length/protocol error (code 4) and goes to DRAIN.
- TOKEN: accepts exactly 2 bytes.
  - tok_addr = b1[6:0]; tok_endp = {b2[2:0], b1[7]}; frame_num = {b2[2:0], b1}.
  - The token is evaluated when rx_active falls.
- HSHK: any byte after the PID gives length error code 4.
- DATA:
  - Bytes enter a 2-deep holding pipeline. A byte is emitted on data/data_valid the cycle after a third byte is accepted, so the final 2 bytes (the CRC16) are never emitted.
  - Accepting a byte when payload count is already MAX_DATA_LEN+2 gives overflow code 6. Further bytes are ignored until rx_active falls.
- End of packet: on the first cycle rx_active is sampled low in PID/TOKEN/DATA/HSHK/DRAIN, register pkt_done=1 next cycle, then return to IDLE.
  - pkt_ok is asserted if no error is latched and all of the following hold:
    - TOKEN: 2 bytes and CRC5 residual good; this also pulses tok_valid in the same cycle as pkt_done.
    - DATA: at least 2 bytes and CRC16 residual good.
    - HSHK: 0 extra bytes.
  - Otherwise pkt_err with the highest-priority code, priority 5 > 1 > 6 > 4 > 2/3.
  - A PID-only packet (rx_active falls in PID state with no byte) gives code 4.
- rx_error with rx_active high: latch code 5, go to DRAIN. Coincident rx_valid bytes are discarded.
- rx_valid while rx_active is low is ignored.
- Back-to-back packets: rx_active may rise again in the cycle pkt_done is high; it is accepted. IDLE is also entered combinationally from the end state.

Test Plan:
- SETUP addr 0 endp 0: bytes 2D,00,10 -> pid_valid with pid=D; pkt_done, pkt_ok and tok_valid together; tok_addr=0, tok_endp=0.
- DATA0 GET_DESCRIPTOR: C3,80,06,00,01,00,00,40,00,DD,94 -> pid=3; 8 data strobes 80,06,00,01,00,00,40,00 in order; DD and 94 not emitted; pkt_ok.
- Same DATA0 packet with last byte 95 -> 8 strobes, then pkt_err, err_code=3. Zero-length DATA1 4B,00,00 -> no data_valid, pkt_ok.
- Bad PID 2C,00,10 -> no pid_valid, pkt_err err_code=1. ACK D2 alone -> pkt_ok. ACK D2,00 -> err_code=4.
- rx_error pulse mid-DATA -> pkt_err err_code=5 only after rx_active falls. rst mid-token -> all outputs 0, no pkt_done; next SETUP decodes correctly.
- DATA0 with MAX_DATA_LEN+1 payload bytes plus CRC -> err_code=6. Back-to-back SETUP then DATA0 with rx_active re-rising in the pkt_done cycle -> both packets pkt_ok.
